// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and the slot state encoding for the 1-to-4 stream demux.
//   NUM_CH       : number of output channels
//   SEL_W        : width of the channel select
//   slot_state_t : per-channel one-entry buffer state (EMPTY=0, FULL=1)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_1to4_stream_if.sv
// -----------------------------------------------------------------------------
// demux_1to4_stream_if
// Bundles the upstream stream and the four downstream channels of the demux.
//   in_data/in_sel/in_valid/in_ready : upstream word, destination, handshake
//   out_data  [NUM_CH*W]  : channel k data at [k*W +: W]
//   out_valid [NUM_CH]    : channel k holds a word
//   out_ready [NUM_CH]    : channel k consumer takes the word this cycle
//   out_count [NUM_CH*CW] : channel k accepted-word count at [k*CW +: CW]
// Modports: master = traffic source/sink around the block, slave = the demux.
// -----------------------------------------------------------------------------
interface demux_1to4_stream_if
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) ();

    logic [W-1:0]         in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_CH*W-1:0]  out_data;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic [NUM_CH*CW-1:0] out_count;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_count
    );

endinterface

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One channel of the demux: a one-entry output register, its EMPTY/FULL FSM
// and a wrapping count of words written into it.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : write wr_data this cycle (already qualified by the top)
//   wr_data    : word to store
//   rd_ready   : downstream consumes the held word this cycle
//   valid      : slot is FULL
//   data       : held word (keeps last value when EMPTY)
//   count      : number of writes, modulo 2^CW
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no word held, valid=0
// FULL  | word held on data, valid=1 until consumed
// -----------------------------------------------------------------------------
module demux_slot
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_ready,
    output logic          valid,
    output logic [W-1:0]  data,
    output logic [CW-1:0] count
);

    slot_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                // A write wins over a drain: simultaneous read+write stays FULL
                // with the new word, giving back-to-back throughput.
                state <= SLOT_FULL;
                data  <= wr_data;
                count <= count + CW'(1);
            end else if (state == SLOT_FULL && rd_ready) begin
                state <= SLOT_EMPTY;
            end
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1to4_stream.sv
// -----------------------------------------------------------------------------
// demux_1to4_stream
// Routes each accepted upstream word to one of four independently drained
// channels selected by in_sel. Each channel is a one-entry registered slot,
// so a word appears on its channel one cycle after acceptance.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : demux_1to4_stream_if.slave (stream in, four channels out, counts)
// -----------------------------------------------------------------------------
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input logic                 clk,
    input logic                 rst,
    demux_1to4_stream_if.slave  bus
);

    logic [NUM_CH-1:0]    slot_valid;
    logic [NUM_CH*W-1:0]  slot_data;
    logic [NUM_CH*CW-1:0] slot_count;
    logic [NUM_CH-1:0]    wr_en;
    logic                 in_ready_c;

    // Only the selected channel gates acceptance; a stalled channel never
    // blocks traffic to the others. Held low during reset.
    always_comb begin
        in_ready_c = ~rst & (~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
    end

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_en[k] = bus.in_valid & in_ready_c & (bus.in_sel == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .W  (W),
            .CW (CW)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[k]),
            .wr_data  (bus.in_data),
            .rd_ready (bus.out_ready[k]),
            .valid    (slot_valid[k]),
            .data     (slot_data[k*W +: W]),
            .count    (slot_count[k*CW +: CW])
        );
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.out_count = slot_count;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_stream
// Directed bench for demux_1to4_stream: stimulus pushes expected words into
// per-channel queues, a monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_demux_1to4_stream;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_1to4_stream_if #(.W(8), .CW(8)) bus ();

    demux_1to4_stream #(.W(8), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [4][$];
    logic [7:0] cnt   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_vec();
        return {cnt[3], cnt[2], cnt[1], cnt[0]};
    endfunction

    // Drive one cycle of inputs after the edge, then at the falling edge check
    // in_ready against the expectation and record the word if it goes in.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] s,
                         input logic [3:0] ordy, input logic exp_rdy, input string tag);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        @(negedge clk);
        chk({tag, " in_ready"}, {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        if (v && exp_rdy) begin
            exp_q[s].push_back(d);
            cnt[s] = cnt[s] + 8'd1;
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected ch%0d: got %h expected none", k,
                                 bus.out_data[k*8 +: 8]);
                    end else begin
                        chk($sformatf("ch%0d data", k), {24'b0, bus.out_data[k*8 +: 8]},
                            {24'b0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) cnt[k] = 8'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'hF;

        // Reset: in_ready low while rst, clean state after release
        @(negedge clk);
        chk("rst in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post-rst out_valid", {28'b0, bus.out_valid}, 32'd0);
        chk("post-rst out_data", bus.out_data, 32'd0);
        chk("post-rst out_count", bus.out_count, 32'd0);
        chk("post-rst in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Route one word to each channel
        cycle(1'b1, 8'h11, 2'd0, 4'hF, 1'b1, "route0");
        cycle(1'b1, 8'h22, 2'd1, 4'hF, 1'b1, "route1");
        chk("route ov0", {28'b0, bus.out_valid}, 32'h1);
        chk("route d0", {24'b0, bus.out_data[7:0]}, 32'h11);
        cycle(1'b1, 8'h33, 2'd2, 4'hF, 1'b1, "route2");
        chk("route ov1", {28'b0, bus.out_valid}, 32'h2);
        cycle(1'b1, 8'h44, 2'd3, 4'hF, 1'b1, "route3");
        chk("route ov2", {28'b0, bus.out_valid}, 32'h4);
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "route idle");
        chk("route ov3", {28'b0, bus.out_valid}, 32'h8);
        chk("route counts", bus.out_count, 32'h01010101);

        // Backpressure on channel 2
        cycle(1'b1, 8'hA5, 2'd2, 4'b1011, 1'b1, "bp first");
        cycle(1'b1, 8'h5A, 2'd2, 4'b1011, 1'b0, "bp blocked");
        chk("bp ov2", {31'b0, bus.out_valid[2]}, 32'd1);
        chk("bp hold1", {24'b0, bus.out_data[23:16]}, 32'hA5);
        cycle(1'b1, 8'h5A, 2'd2, 4'b1011, 1'b0, "bp blocked2");
        chk("bp hold2", {24'b0, bus.out_data[23:16]}, 32'hA5);
        cycle(1'b1, 8'h5A, 2'd2, 4'b1111, 1'b1, "bp release");
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "bp idle");
        chk("bp new ov2", {31'b0, bus.out_valid[2]}, 32'd1);
        chk("bp new d2", {24'b0, bus.out_data[23:16]}, 32'h5A);

        // Head-of-line independence: ch2 stalled, ch1 still flows
        cycle(1'b1, 8'hC3, 2'd2, 4'b1011, 1'b1, "hol fill2");
        cycle(1'b1, 8'h77, 2'd1, 4'b1011, 1'b1, "hol send1");
        chk("hol ov", {28'b0, bus.out_valid}, 32'h4);
        cycle(1'b0, 8'h00, 2'd0, 4'b1011, 1'b1, "hol idle");
        chk("hol ov2", {28'b0, bus.out_valid}, 32'h6);
        chk("hol d1", {24'b0, bus.out_data[15:8]}, 32'h77);
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "hol drain");
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "hol empty");
        chk("hol all empty", {28'b0, bus.out_valid}, 32'h0);

        // Simultaneous drain and refill on channel 0
        cycle(1'b1, 8'h01, 2'd0, 4'hF, 1'b1, "dr fill");
        cycle(1'b1, 8'h02, 2'd0, 4'hF, 1'b1, "dr refill");
        chk("dr ov0 a", {31'b0, bus.out_valid[0]}, 32'd1);
        chk("dr d0 a", {24'b0, bus.out_data[7:0]}, 32'h01);
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "dr idle");
        chk("dr ov0 b", {31'b0, bus.out_valid[0]}, 32'd1);
        chk("dr d0 b", {24'b0, bus.out_data[7:0]}, 32'h02);
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "dr idle2");
        chk("dr ov0 c", {31'b0, bus.out_valid[0]}, 32'd0);

        // Counter wrap on channel 3: bring it round to exactly 0
        begin
            int n;
            n = 256 - int'(cnt[3]);
            for (int i = 0; i < n; i++) begin
                cycle(1'b1, 8'(i), 2'd3, 4'hF, 1'b1, "wrap");
            end
        end
        cycle(1'b0, 8'h00, 2'd0, 4'hF, 1'b1, "wrap idle");
        chk("wrap cnt3", {24'b0, bus.out_count[31:24]}, 32'h0);
        chk("wrap counts", bus.out_count, cnt_vec());

        // Reset mid-operation: all slots full and stalled
        cycle(1'b1, 8'hA0, 2'd0, 4'h0, 1'b1, "mr fill0");
        cycle(1'b1, 8'hA1, 2'd1, 4'h0, 1'b1, "mr fill1");
        cycle(1'b1, 8'hA2, 2'd2, 4'h0, 1'b1, "mr fill2");
        cycle(1'b1, 8'hA3, 2'd3, 4'h0, 1'b1, "mr fill3");
        cycle(1'b0, 8'h00, 2'd0, 4'h0, 1'b0, "mr full");
        chk("mr ov full", {28'b0, bus.out_valid}, 32'hF);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_sel   = 2'd1;
        @(negedge clk);
        chk("mr rst in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            cnt[k] = 8'd0;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mr ov", {28'b0, bus.out_valid}, 32'h0);
        chk("mr counts", bus.out_count, cnt_vec());
        chk("mr data", bus.out_data, 32'h0);
        chk("mr in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mr release in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mr release ov", {28'b0, bus.out_valid}, 32'h0);

        // Every expected word must have been seen
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("leftover ch%0d", k), exp_q[k].size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
